// File: rtl/byte_pack_arbiter.sv
// Round-robin arbiter that packs two bytes from the granted requester into one
// ID-tagged 16-bit word. Define PACK_TIMEOUT_EN to abort partial words that stall in BYTE1.
module byte_pack_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_timeout
);

  typedef enum logic [1:0] {ARB, BYTE0, BYTE1, OUT} state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] arb_pick;
  logic [IDW-1:0] cand;
  logic           any_valid;
  logic [15:0]    word;
  logic           grant_valid;
  logic [7:0]     grant_byte;
  logic           abort;

  assign grant_valid = req_valid[grant];
  assign grant_byte  = req_data[{grant, 3'b000} +: 8];

  // Search starts just after the last served requester so each one waits at most NREQ-1 words.
  always_comb begin
    arb_pick  = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        arb_pick  = cand;
      end
    end
  end

`ifdef PACK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 2);

  logic [CW-1:0] tcount;
  logic          err_q;

  // A byte in the expiry cycle wins over the abort because grant_valid is checked first.
  assign abort       = (state == BYTE1) && !grant_valid && ((int'(tcount) + 1) >= TIMEOUT);
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcount <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (state != BYTE1)
        tcount <= '0;
      else if (!grant_valid)
        tcount <= tcount + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      last_grant <= IDW'(NREQ - 1);
      grant      <= '0;
      word       <= '0;
    end else begin
      state <= state_next;
      if (state == ARB && any_valid)
        grant <= arb_pick;
      if (state == BYTE0 && grant_valid)
        word[15:8] <= grant_byte;
      if (state == BYTE1 && grant_valid)
        word[7:0] <= grant_byte;
      if ((state == OUT && out_ready) || abort)
        last_grant <= grant;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (any_valid) state_next = BYTE0;
      BYTE0:   if (grant_valid) state_next = BYTE1;
      BYTE1:   if (grant_valid) state_next = OUT;
               else if (abort) state_next = ARB;
      OUT:     if (out_ready) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Ready is decoded from state and grant only, so it never depends on req_valid.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_id    = '0;
    busy      = (state != ARB);
    case (state)
      BYTE0, BYTE1: req_ready[grant] = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        out_data  = word;
        out_id    = grant;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_byte_pack_arbiter.sv
// Directed scenarios plus randomized traffic for byte_pack_arbiter, scored against
// a word-level model: per-requester word queues served nearest-pending-after-last-served.
module tb_byte_pack_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
  logic              busy;
  logic              err_timeout;

  always #5 clk = ~clk;

  byte_pack_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  logic [7:0]     bq [NREQ][$];
  logic [15:0]    wq [NREQ][$];
  int             gap_left [NREQ];
  int             gap_pct;
  int             ready_pct;
  int             last_id;
  int             n_checks;
  int             n_pass;
  int             n_fail;
  int             err_pulses;
  int             id_log[$];
  logic [15:0]    data_log[$];
  bit             stalled;
  logic [15:0]    held_data;
  logic [IDW-1:0] held_id;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic loadWord(input int i, input logic [7:0] hi, input logic [7:0] lo);
    bq[i].push_back(hi);
    bq[i].push_back(lo);
    wq[i].push_back({hi, lo});
  endtask

  function automatic int pendingWords();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += wq[i].size();
    return n;
  endfunction

  function automatic int expectedId();
    for (int k = 1; k <= NREQ; k++) begin
      int idx = (last_id + k) % NREQ;
      if (wq[idx].size() > 0) return idx;
    end
    return NREQ;
  endfunction

  // One clock cycle: check outputs at the falling edge, drive new inputs, and
  // advance the model by the handshakes that the coming rising edge completes.
  task automatic applyStimulus();
    logic [NREQ-1:0] fire;
    int exp_id;
    @(negedge clk);
    checkOutput("ready_onehot", ($countones(req_ready) <= 1), 1);
    checkOutput("busy", busy, (|req_ready) | out_valid);
    if (out_valid) checkOutput("ready_during_out", req_ready, 0);
    if (stalled) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_data", out_data, held_data);
      checkOutput("stall_id", out_id, held_id);
    end
`ifndef PACK_TIMEOUT_EN
    checkOutput("err_idle", err_timeout, 0);
`endif
    if (err_timeout) err_pulses++;
    for (int i = 0; i < NREQ; i++) begin
      if (bq[i].size() == 0) begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
      end else begin
        req_data[8*i +: 8] = bq[i][0];
        if (bq[i].size() % 2 == 1 && gap_left[i] > 0) begin
          req_valid[i] = 1'b0;
          gap_left[i]--;
        end else if (bq[i].size() % 2 == 1 && $urandom_range(99) < gap_pct)
          req_valid[i] = 1'b0;
        else
          req_valid[i] = 1'b1;
      end
    end
    out_ready = ($urandom_range(99) < ready_pct);
    fire = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (fire[i]) void'(bq[i].pop_front());
    if (out_valid && out_ready) begin
      exp_id = expectedId();
      checkOutput("word_id", out_id, exp_id);
      if (exp_id < NREQ) begin
        checkOutput("word_data", out_data, wq[exp_id][0]);
        void'(wq[exp_id].pop_front());
        last_id = exp_id;
      end
      id_log.push_back(int'(out_id));
      data_log.push_back(out_data);
    end
    stalled   = out_valid && !out_ready;
    held_data = out_data;
    held_id   = out_id;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_id", out_id, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_timeout, 0);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bq[i].delete();
      wq[i].delete();
      gap_left[i] = 0;
    end
    last_id = NREQ - 1;
    stalled = 1'b0;
  endtask

  task automatic runUntilDrained(input string tag, input int budget);
    int n = 0;
    while ((pendingWords() > 0 || busy) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, pendingWords(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int saw_out;
    req_data  = '0;
    gap_pct   = 0;
    ready_pct = 100;
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    doReset();

    // Single requester, back-to-back bytes: word appears three cycles after the grant cycle.
    loadWord(2, 8'hAB, 8'hCD);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!out_valid && n < 10);
    checkOutput("latency", n, 4);
    checkOutput("t1_data", out_data, 16'hABCD);
    checkOutput("t1_id", out_id, 2);
    applyStimulus();
    checkOutput("t1_busy_drop", busy, 0);

    // All four hold valid: strict rotation starting from requester 0.
    doReset();
    id_log.delete();
    for (int i = 0; i < NREQ; i++) loadWord(i, 8'(16 + i), 8'(32 + i));
    loadWord(0, 8'h30, 8'h40);
    runUntilDrained("t2_drain", 60);
    checkOutput("t2_count", id_log.size(), 5);
    if (id_log.size() == 5) begin
      checkOutput("t2_id0", id_log[0], 0);
      checkOutput("t2_id1", id_log[1], 1);
      checkOutput("t2_id2", id_log[2], 2);
      checkOutput("t2_id3", id_log[3], 3);
      checkOutput("t2_id4", id_log[4], 0);
    end

    // Granted requester pauses between bytes; the grant must not move to requester 0.
    id_log.delete();
    data_log.delete();
    loadWord(1, 8'h55, 8'h66);
    loadWord(0, 8'h01, 8'h02);
    gap_left[1] = 5;
    runUntilDrained("t3_drain", 60);
    checkOutput("t3_count", id_log.size(), 2);
    if (id_log.size() == 2) begin
      checkOutput("t3_first_id", id_log[0], 1);
      checkOutput("t3_first_data", data_log[0], 16'h5566);
      checkOutput("t3_second_id", id_log[1], 0);
    end

    // Backpressure for seven cycles: output held stable until accepted.
    data_log.delete();
    ready_pct = 0;
    loadWord(3, 8'h12, 8'h34);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!out_valid && n < 10);
    checkOutput("t4_reach_out", out_valid, 1);
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("t4_still_valid", out_valid, 1);
    ready_pct = 100;
    runUntilDrained("t4_drain", 20);
    checkOutput("t4_data", (data_log.size() == 1) ? data_log[0] : 16'h0, 16'h1234);

    // Reset while a partial word sits in BYTE1; the next word carries no residue.
    data_log.delete();
    bq[0].push_back(8'h77);
    bq[0].push_back(8'h00);
    gap_left[0] = 1000;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (bq[0].size() != 1 && n < 10);
    applyStimulus();
    checkOutput("t5_in_byte1", req_ready, 4'b0001);
    doReset();
    loadWord(0, 8'h88, 8'h99);
    runUntilDrained("t5_drain", 20);
    checkOutput("t5_data", (data_log.size() == 1) ? data_log[0] : 16'h0, 16'h8899);

    // Requester 2 goes silent after its first byte; requester 3 waits behind it.
    id_log.delete();
    data_log.delete();
    err_pulses = 0;
    loadWord(2, 8'hEE, 8'h11);
    loadWord(3, 8'h3A, 8'h3B);
    gap_left[2] = 100000;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (bq[2].size() != 1 && n < 10);
    checkOutput("t6_byte0_taken", bq[2].size(), 1);
`ifdef PACK_TIMEOUT_EN
    n = 0;
    saw_out = 0;
    do begin
      applyStimulus();
      n++;
      if (out_valid) saw_out++;
    end while (err_pulses == 0 && n < 40);
    checkOutput("t6_timeout_delay", n, TIMEOUT + 1);
    checkOutput("t6_no_out", saw_out, 0);
    bq[2].delete();
    wq[2].delete();
    gap_left[2] = 0;
    last_id = 2;
    runUntilDrained("t6_drain", 30);
    checkOutput("t6_single_pulse", err_pulses, 1);
    checkOutput("t6_next_id", (id_log.size() == 1) ? id_log[0] : NREQ, 3);
`else
    saw_out = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus();
      if (out_valid) saw_out++;
    end
    checkOutput("t7_no_out", saw_out, 0);
    checkOutput("t7_hold_grant", req_ready, 4'b0100);
    checkOutput("t7_no_err", err_pulses, 0);
    gap_left[2] = 0;
    runUntilDrained("t7_drain", 30);
    checkOutput("t7_count", id_log.size(), 2);
    if (id_log.size() == 2) begin
      checkOutput("t7_first_id", id_log[0], 2);
      checkOutput("t7_first_data", data_log[0], 16'hEE11);
      checkOutput("t7_second_id", id_log[1], 3);
    end
`endif

    // Randomized traffic with mid-word gaps and random backpressure.
    gap_pct   = 30;
    ready_pct = 60;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        int nw = $urandom_range(3);
        for (int w = 0; w < nw; w++) loadWord(i, 8'($urandom), 8'($urandom));
      end
      runUntilDrained("rand_drain", 400);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
